// File: rtl/demux_1x4_tdm.sv
// rtl/demux_1x4_tdm.sv - registered 1-to-4 demux with manual or round-robin (TDM) lane steering
// Tracks per-frame lane coverage, frame completion and manual-mode duplicate writes.
module demux_1x4_tdm #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  input  logic             s1_i,
  input  logic             s0_i,
  input  logic             auto_mode_i,
  input  logic             sync_i,
  output logic [WIDTH-1:0] y0_o,
  output logic [WIDTH-1:0] y1_o,
  output logic [WIDTH-1:0] y2_o,
  output logic [WIDTH-1:0] y3_o,
  output logic [3:0]       lane_valid_o,
  output logic             frame_done_o,
  output logic             dup_err_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [3:0]         mask_q, mask_d;
  logic               auto_q;
  logic [WIDTH-1:0]   y_q [4];
  logic [WIDTH-1:0]   y_d [4];
  logic [3:0]         lane_valid_q, lane_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               dup_err_q, dup_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               restart;
  logic [1:0]         slot_base;
  logic [3:0]         mask_base;
  logic [1:0]         idx;
  logic [3:0]         onehot;
  logic [3:0]         mask_new;

  always_comb begin
    // A mode change is treated like sync so a frame never mixes steering modes.
    restart   = sync_i | (auto_mode_i ^ auto_q);
    slot_base = restart ? 2'd0 : slot_q;
    mask_base = restart ? 4'd0 : mask_q;
    idx       = auto_mode_i ? slot_base : {s1_i, s0_i};
    onehot    = 4'b0001 << idx;
    mask_new  = mask_base | onehot;

    state_d      = state_q;
    slot_d       = slot_base;
    mask_d       = mask_base;
    y_d          = y_q;
    lane_valid_d = 4'd0;
    frame_done_d = 1'b0;
    dup_err_d    = 1'b0;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE:    if (din_valid_i) state_d = COLLECT;
      COLLECT: state_d = COLLECT;
      default: state_d = IDLE;
    endcase

    if (din_valid_i) begin
      y_d[idx]     = din_i;
      lane_valid_d = onehot;
      if (auto_mode_i) slot_d = slot_base + 2'd1;
      if (!auto_mode_i && ((mask_base & onehot) != 4'd0)) begin
        dup_err_d = 1'b1;
      end else if (mask_new == 4'hF) begin
        frame_done_d = 1'b1;
        mask_d       = 4'd0;
        cnt_d        = cnt_q + 1'b1;
      end else begin
        mask_d = mask_new;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      slot_q       <= 2'd0;
      mask_q       <= 4'd0;
      auto_q       <= 1'b0;
      for (int i = 0; i < 4; i++) y_q[i] <= '0;
      lane_valid_q <= 4'd0;
      frame_done_q <= 1'b0;
      dup_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      mask_q       <= mask_d;
      auto_q       <= auto_mode_i;
      y_q          <= y_d;
      lane_valid_q <= lane_valid_d;
      frame_done_q <= frame_done_d;
      dup_err_q    <= dup_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign y0_o         = y_q[0];
  assign y1_o         = y_q[1];
  assign y2_o         = y_q[2];
  assign y3_o         = y_q[3];
  assign lane_valid_o = lane_valid_q;
  assign frame_done_o = frame_done_q;
  assign dup_err_o    = dup_err_q;
  assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_demux_1x4_tdm.sv
// tb/tb_demux_1x4_tdm.sv - directed vector bench for demux_1x4_tdm
module tb_demux_1x4_tdm;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] din_i;
  logic       din_valid_i, s1_i, s0_i, auto_mode_i, sync_i;
  logic [7:0] y0_o, y1_o, y2_o, y3_o;
  logic [3:0] lane_valid_o;
  logic       frame_done_o, dup_err_o;
  logic [7:0] frame_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  demux_1x4_tdm #(.WIDTH(8), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .din_i(din_i), .din_valid_i(din_valid_i),
    .s1_i(s1_i), .s0_i(s0_i), .auto_mode_i(auto_mode_i), .sync_i(sync_i),
    .y0_o(y0_o), .y1_o(y1_o), .y2_o(y2_o), .y3_o(y3_o),
    .lane_valid_o(lane_valid_o), .frame_done_o(frame_done_o),
    .dup_err_o(dup_err_o), .frame_cnt_o(frame_cnt_o)
  );

  typedef struct packed {
    logic        v;
    logic [1:0]  s;
    logic        a;
    logic        sy;
    logic [7:0]  d;
    logic [31:0] ey;   // {y3,y2,y1,y0}
    logic [3:0]  elv;
    logic        efd;
    logic        edup;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ey, input logic [3:0] elv,
                         input logic efd, input logic edup, input logic [7:0] ecnt);
    chk({tag, " y"},    {y3_o, y2_o, y1_o, y0_o}, ey);
    chk({tag, " lv"},   {28'd0, lane_valid_o}, {28'd0, elv});
    chk({tag, " fd"},   {31'd0, frame_done_o}, {31'd0, efd});
    chk({tag, " dup"},  {31'd0, dup_err_o}, {31'd0, edup});
    chk({tag, " cnt"},  {24'd0, frame_cnt_o}, {24'd0, ecnt});
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic a, input logic sy,
                       input logic [7:0] d);
    @(negedge clk_i);
    din_valid_i = v; {s1_i, s0_i} = s; auto_mode_i = a; sync_i = sy; din_i = d;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int fd_seen;
    logic [31:0] held;

    vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 8'hA1, 32'h000000A1, 4'b0001, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 2'd0, 1'b1, 1'b0, 8'hB2, 32'h0000B2A1, 4'b0010, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 2'd0, 1'b1, 1'b0, 8'hC3, 32'h00C3B2A1, 4'b0100, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 2'd0, 1'b1, 1'b0, 8'hD4, 32'hD4C3B2A1, 4'b1000, 1'b1, 1'b0, 8'd1};
    vecs[4]  = '{1'b1, 2'd3, 1'b0, 1'b0, 8'h11, 32'h11C3B2A1, 4'b1000, 1'b0, 1'b0, 8'd1};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 1'b0, 8'h22, 32'h11C322A1, 4'b0010, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h33, 32'h11C32233, 4'b0001, 1'b0, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 8'h44, 32'h11442233, 4'b0100, 1'b1, 1'b0, 8'd2};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 1'b0, 8'h55, 32'h11552233, 4'b0100, 1'b0, 1'b0, 8'd2};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 1'b0, 8'h66, 32'h11662233, 4'b0100, 1'b0, 1'b1, 8'd2};
    vecs[10] = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h01, 32'h11662201, 4'b0001, 1'b0, 1'b0, 8'd2};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 1'b0, 8'h02, 32'h11660201, 4'b0010, 1'b0, 1'b0, 8'd2};
    vecs[12] = '{1'b1, 2'd3, 1'b0, 1'b0, 8'h03, 32'h03660201, 4'b1000, 1'b1, 1'b0, 8'd3};
    vecs[13] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'h81, 32'h03660281, 4'b0001, 1'b0, 1'b0, 8'd3};
    vecs[14] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'h82, 32'h03668281, 4'b0010, 1'b0, 1'b0, 8'd3};
    vecs[15] = '{1'b1, 2'd0, 1'b1, 1'b1, 8'h77, 32'h03668277, 4'b0001, 1'b0, 1'b0, 8'd3};
    vecs[16] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'h83, 32'h03668377, 4'b0010, 1'b0, 1'b0, 8'd3};
    vecs[17] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'h84, 32'h03848377, 4'b0100, 1'b0, 1'b0, 8'd3};
    vecs[18] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'h85, 32'h85848377, 4'b1000, 1'b1, 1'b0, 8'd4};

    rst_ni = 1'b0; din_i = 8'h00; din_valid_i = 1'b0; s1_i = 1'b0; s0_i = 1'b0;
    auto_mode_i = 1'b0; sync_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_all("reset", 32'h0, 4'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].a, vecs[i].sy, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].ey, vecs[i].elv, vecs[i].efd, vecs[i].edup,
              vecs[i].ecnt);
    end

    // Idle cycles with random data/select must leave everything held.
    held = 32'h85848377;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 1'b1, 1'b0, 8'($urandom));
      chk_all($sformatf("idle%0d", i), held, 4'b0, 1'b0, 1'b0, 8'd4);
    end

    // 251 more frames bring the count to 255, one more wraps it to 0.
    fd_seen = 0;
    for (int f = 0; f < 252; f++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b1, 2'd0, 1'b1, 1'b0, 8'(f + k));
        if (frame_done_o) fd_seen++;
      end
      if (f == 250) chk("cnt_max", {24'd0, frame_cnt_o}, 32'd255);
    end
    chk("cnt_wrap", {24'd0, frame_cnt_o}, 32'd0);
    chk("fd_pulses", fd_seen, 32'd252);

    drive(1'b1, 2'd0, 1'b1, 1'b0, 8'hE0);
    drive(1'b1, 2'd0, 1'b1, 1'b0, 8'hE1);
    chk("partial_lv", {28'd0, lane_valid_o}, 32'b0010);
    @(negedge clk_i);
    din_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 4'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b1, 2'd0, 1'b1, 1'b0, 8'h99);
    chk_all("post_rst", 32'h00000099, 4'b0001, 1'b0, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1x4_tdm.md
Name: demux_1x4_tdm

Overview:
- Registered 1-to-4 demultiplexer; inverse of the 4:1 data-select path.
- Accepts one WIDTH-bit sample per valid cycle and steers it to one of four held output lanes.
- Lane choice is either the {s1,s0} select (manual mode) or an internal round-robin slot counter (auto/TDM mode).
- Tracks frame completion when all four lanes have been written, and flags duplicate writes within a frame.

Parameters:
- WIDTH, 8, sample/lane data width in bits.
- CNT_W, 8, frame counter width in bits.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  input sample.
- din_valid  input  1  sample accepted on this rising edge when high.
- s1  input  1  manual select MSB.
- s0  input  1  manual select LSB.
- auto_mode  input  1  1 = round-robin slot steering, 0 = {s1,s0} steering.
- sync  input  1  restarts the frame (clears slot counter and written mask).
- y0..y3  output  WIDTH each  held lane outputs, indexed by {s1,s0} = 0..3.
- lane_valid  output  4  one-cycle strobe; bit n = lane n updated.
- frame_done  output  1  one-cycle strobe; all four lanes written in the current frame.
- dup_err  output  1  one-cycle strobe; manual write to a lane already written this frame.
- frame_cnt  output  CNT_W  completed-frame count.

Behaviour:
- Reset (async assert, sync deassert on the next clk edge):
  - y0..y3 = 0, lane_valid = 0, frame_done = 0, dup_err = 0, frame_cnt = 0.
  - Slot counter = 0, written mask = 4'b0000, state = IDLE.
- States:
  - IDLE: entered after reset. Moves to COLLECT on the first accepted sample; that sample is processed normally.
  - COLLECT: normal operation. Returns to IDLE only on reset.
- Lane index:
  - auto_mode=1: idx = slot counter.
  - auto_mode=0: idx = {s1,s0}, sampled on the same edge as din.
- Accepted sample (din_valid=1) on an edge:
  - y[idx] <= din.
  - lane_valid <= one-hot(idx); all other bits 0. Latency is 1 cycle: data and strobe appear together after the edge.
  - Mask bit idx is set.
  - Auto mode only: slot counter advances 0→1→2→3→0.
- Frame completion:
  - When the mask including this write equals 4'b1111: frame_done <= 1, mask cleared to 0, frame_cnt increments.
  - frame_done is asserted in the same cycle as the completing lane_valid.
  - frame_cnt wraps from max to 0 without a flag.
- Duplicate write (manual mode):
  - Writing a lane whose mask bit is already set: dup_err pulses 1 cycle.
  - Data still overwrites the lane, lane_valid still pulses, mask is unchanged, and no frame completes.
  - In auto mode dup_err is always 0.
- No sample (din_valid=0):
  - lane_valid, frame_done and dup_err are 0.
  - All state and outputs hold.
- sync:
  - Clears slot counter and mask before the same-edge sample is processed.
  - sync together with din_valid: the sample is the first write of the new frame (auto: lane 0).
  - sync does not alter y0..y3 or frame_cnt.
- auto_mode change between cycles acts as an implicit sync on the edge where the new value is first seen.
- Reset mid-frame: all outputs return to reset values immediately (async), and partial-frame progress is discarded.

Test Plan:
- Auto mode: samples 0xA1, 0xB2, 0xC3, 0xD4 on 4 consecutive edges → y0..y3 = A1, B2, C3, D4; lane_valid = 0001, 0010, 0100, 1000; frame_done on the 4th only; frame_cnt = 1.
- Manual mode: {s1,s0} = 3, 1, 0, 2 with data 0x11, 0x22, 0x33, 0x44 → y3=11, y1=22, y0=33, y2=44; frame_done with the 4th; no dup_err.
- Manual duplicate: write lane 2 = 0x55 then lane 2 = 0x66 → dup_err pulses on the 2nd, y2 = 0x66, no frame_done until lanes 0, 1, 3 are written.
- Auto mode: 2 samples, then sync together with 0x77 → y0 = 0x77, slot = 1; 3 more samples needed before frame_done.
- Drive din_valid=0 with random din/select for 10 cycles → outputs held, all strobes 0.
- 256 auto frames → frame_cnt wraps to 0. Assert rst_n low mid-frame → all outputs 0 asynchronously; after release, the next sample lands in y0.
